// File: rtl/spi_slave_if.sv
// ============================================================================
// Module      : spi_slave_if
// Description : Peripheral-bus control signals and SPI pins of the SPI
//               responder, bundled for connection between the bus/pad side
//               (master modport) and the spi_slave core (slave modport).
//               The bidirectional bus_data lines stay a plain module port
//               so the tristate resolves at the pad level.
// Signals     : periph_sel, bus_we, bus_oe, periph_addr[ADDR_N] - CPU bus
//               cs (active low), sck, mosi                      - SPI in
//               miso, miso_oe, interrupt                        - outputs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_slave_if #(
  parameter int ADDR_N = 2
);
  logic              periph_sel;
  logic              bus_we;
  logic              bus_oe;
  logic [ADDR_N-1:0] periph_addr;
  logic              cs;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              interrupt;

  // Bus / pad side: drives strobes and SPI pins, observes responder outputs.
  modport master (
    output periph_sel, bus_we, bus_oe, periph_addr, cs, sck, mosi,
    input  miso, miso_oe, interrupt
  );

  // Responder core side.
  modport slave (
    input  periph_sel, bus_we, bus_oe, periph_addr, cs, sck, mosi,
    output miso, miso_oe, interrupt
  );
endinterface

`default_nettype wire

// File: rtl/spi_slave.sv
// ============================================================================
// Module      : spi_slave
// Description : SPI responder (mode 0, MSB first, DATA_N bits per byte) with
//               a CPU register interface on the shared peripheral bus.
//               Registers: 0 DATA (rd rx_buf / wr tx_buf), 1 STATUS,
//               2 CTRL, 3 reads 0.
// Ports       : clk        - system clock, rising edge
//               n_reset    - asynchronous active-low reset
//               bus        - spi_slave_if.slave (bus strobes, address,
//                            cs/sck/mosi in, miso/miso_oe/interrupt out)
//               bus_data   - DATA_N bidirectional data, driven only while
//                            periph_sel && bus_oe
// Config      : `DATA_N           - default shift width (8 when undefined)
//               SPI_SLAVE_IRQ_EN  - when defined, CTRL[1] irq_en is stored
//                                   and drives a registered level interrupt;
//                                   otherwise interrupt is tied 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_N
`define DATA_N 8
`endif

module spi_slave #(
  parameter int DATA_N = `DATA_N,
  parameter int ADDR_N = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  spi_slave_if.slave        bus,
  inout  wire  [DATA_N-1:0] bus_data
);

  localparam int CNT_W = (DATA_N > 2) ? $clog2(DATA_N) : 1;

  localparam logic [ADDR_N-1:0] c_addr_data   = ADDR_N'(0);
  localparam logic [ADDR_N-1:0] c_addr_status = ADDR_N'(1);
  localparam logic [ADDR_N-1:0] c_addr_ctrl   = ADDR_N'(2);
  localparam logic [CNT_W-1:0]  c_last_bit    = CNT_W'(DATA_N - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Pin synchronisers (cs idles high, sck idles low in mode 0)
  // --------------------------------------------------------------------------
  logic cs_meta_q,   cs_s_q,   cs_prev_q;
  logic sck_meta_q,  sck_s_q,  sck_prev_q;
  logic mosi_meta_q, mosi_s_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cs_meta_q   <= 1'b1;
      cs_s_q      <= 1'b1;
      cs_prev_q   <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_s_q     <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      cs_meta_q   <= bus.cs;
      cs_s_q      <= cs_meta_q;
      cs_prev_q   <= cs_s_q;
      sck_meta_q  <= bus.sck;
      sck_s_q     <= sck_meta_q;
      sck_prev_q  <= sck_s_q;
      mosi_meta_q <= bus.mosi;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  logic cs_fall, cs_rise, sck_rise, sck_fall, busy;
  assign cs_fall  =  cs_prev_q  & ~cs_s_q;
  assign cs_rise  = ~cs_prev_q  &  cs_s_q;
  assign sck_rise = ~sck_prev_q &  sck_s_q;
  assign sck_fall =  sck_prev_q & ~sck_s_q;
  assign busy     = ~cs_s_q;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q;
  logic [DATA_N-1:0]  shift_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic               miso_q, miso_oe_q;

  logic [DATA_N-1:0]  rx_buf_q,   rx_buf_d;
  logic [DATA_N-1:0]  tx_buf_q,   tx_buf_d;
  logic               rx_valid_q, rx_valid_d;
  logic               tx_empty_q, tx_empty_d;
  logic               overrun_q,  overrun_d;
  logic               enable_q,   enable_d;
  logic               data_rd_q,  data_rd_d;
`ifdef SPI_SLAVE_IRQ_EN
  logic               irq_en_q,   irq_en_d;
  logic               irq_q,      irq_d;
`endif

  // --------------------------------------------------------------------------
  // Transfer events
  // --------------------------------------------------------------------------
  logic              in_shift, abort, start, bit_evt, done, load;
  logic [DATA_N-1:0] load_val, shift_in;

  assign in_shift = (state_q == ST_SHIFT);
  // cs deassertion or a disabled core terminates any byte in progress.
  assign abort    = in_shift && (cs_rise || !enable_q);
  assign start    = !in_shift && cs_fall && enable_q;
  assign bit_evt  = in_shift && !abort && sck_rise;
  assign done     = bit_evt && (bit_cnt_q == c_last_bit);
  assign load     = start || done;
  assign load_val = tx_empty_q ? '0 : tx_buf_q;
  assign shift_in = {shift_q[DATA_N-2:0], mosi_s_q};

  // --------------------------------------------------------------------------
  // SPI FSM: shift register, bit counter and registered pin outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_SHIFT;
            shift_q   <= load_val;
            bit_cnt_q <= '0;
            // First bit must be on the pin before the first sck rise.
            miso_q    <= load_val[DATA_N-1];
            miso_oe_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
          end else if (bit_evt) begin
            if (done) begin
              shift_q   <= load_val;
              bit_cnt_q <= '0;
            end else begin
              shift_q   <= shift_in;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sck_fall) begin
            // miso changes only on falling sck so the master samples a
            // stable bit on the rising edge.
            miso_q <= shift_q[DATA_N-1];
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          miso_oe_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register file next state
  // --------------------------------------------------------------------------
  logic bus_wr, bus_rd, rd_clear;
  assign bus_wr = bus.periph_sel && bus.bus_we;
  assign bus_rd = bus.periph_sel && bus.bus_oe;

  always_comb begin
    rx_buf_d   = rx_buf_q;
    tx_buf_d   = tx_buf_q;
    rx_valid_d = rx_valid_q;
    tx_empty_d = tx_empty_q;
    overrun_d  = overrun_q;
    enable_d   = enable_q;
`ifdef SPI_SLAVE_IRQ_EN
    irq_en_d   = irq_en_q;
    irq_d      = irq_en_q && (rx_valid_q || overrun_q || (tx_empty_q && busy));
`endif

    // rx_valid clears when a DATA read ends, keeping multi-cycle reads stable.
    data_rd_d = bus_rd && (bus.periph_addr == c_addr_data);
    rd_clear  = data_rd_q && !data_rd_d;

    if (bus_wr && (bus.periph_addr == c_addr_status) && bus_data[2]) begin
      overrun_d = 1'b0;
    end

    if (done) begin
      // A read finishing in the same cycle has consumed the old byte.
      if (rx_valid_q && !rd_clear) begin
        overrun_d = 1'b1;
      end else begin
        rx_buf_d   = shift_in;
        rx_valid_d = 1'b1;
      end
    end else if (rd_clear) begin
      rx_valid_d = 1'b0;
    end

    // A CPU write in the load cycle wins: the load used the old value.
    if (load) begin
      tx_empty_d = 1'b1;
    end
    if (bus_wr && (bus.periph_addr == c_addr_data)) begin
      tx_buf_d   = bus_data;
      tx_empty_d = 1'b0;
    end

    if (bus_wr && (bus.periph_addr == c_addr_ctrl)) begin
      enable_d = bus_data[0];
`ifdef SPI_SLAVE_IRQ_EN
      irq_en_d = bus_data[1];
`endif
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_buf_q   <= '0;
      tx_buf_q   <= '0;
      rx_valid_q <= 1'b0;
      tx_empty_q <= 1'b1;
      overrun_q  <= 1'b0;
      enable_q   <= 1'b0;
      data_rd_q  <= 1'b0;
`ifdef SPI_SLAVE_IRQ_EN
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      rx_buf_q   <= rx_buf_d;
      tx_buf_q   <= tx_buf_d;
      rx_valid_q <= rx_valid_d;
      tx_empty_q <= tx_empty_d;
      overrun_q  <= overrun_d;
      enable_q   <= enable_d;
      data_rd_q  <= data_rd_d;
`ifdef SPI_SLAVE_IRQ_EN
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Combinational read mux and outputs
  // --------------------------------------------------------------------------
  logic [DATA_N-1:0] rd_data;
  logic              irq_en_rd;

`ifdef SPI_SLAVE_IRQ_EN
  assign irq_en_rd     = irq_en_q;
  assign bus.interrupt = irq_q;
`else
  assign irq_en_rd     = 1'b0;
  assign bus.interrupt = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (bus.periph_addr)
      c_addr_data:   rd_data = rx_buf_q;
      c_addr_status: rd_data = {{(DATA_N-4){1'b0}}, busy, overrun_q, tx_empty_q, rx_valid_q};
      c_addr_ctrl:   rd_data = {{(DATA_N-2){1'b0}}, irq_en_rd, enable_q};
      default:       rd_data = '0;
    endcase
  end

  assign bus_data    = bus_rd ? rd_data : {DATA_N{1'bz}};
  assign bus.miso    = miso_q;
  assign bus.miso_oe = miso_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
// Module      : tb_spi_slave
// Description : Directed self-checking bench for spi_slave (8-bit build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave;

`ifdef SPI_SLAVE_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic       clk;
  logic       n_reset;
  logic       tb_drv;
  logic [7:0] tb_wdata;
  wire  [7:0] bus_data;

  int tests = 0;
  int fails = 0;

  spi_slave_if #(.ADDR_N(2)) bus_if ();

  spi_slave #(.DATA_N(8), .ADDR_N(2)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .bus      (bus_if.slave),
    .bus_data (bus_data)
  );

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
    tb_drv                = 1'b1;
    tb_wdata              = v;
    bus_if.periph_addr    = a;
    bus_if.periph_sel     = 1'b1;
    bus_if.bus_we         = 1'b1;
    tick(1);
    bus_if.periph_sel     = 1'b0;
    bus_if.bus_we         = 1'b0;
    tb_drv                = 1'b0;
    tick(1);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus_if.periph_addr = a;
    bus_if.periph_sel  = 1'b1;
    bus_if.bus_oe      = 1'b1;
    tick(1);
    d = bus_data;
    bus_if.periph_sel  = 1'b0;
    bus_if.bus_oe      = 1'b0;
    tick(1);
  endtask

  // Master side of mode 0: set mosi, wait, sample miso, raise sck, lower sck.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus_if.mosi = tx[7-i];
      tick(5);
      rx[7-i]    = bus_if.miso;
      bus_if.sck = 1'b1;
      tick(5);
      bus_if.sck = 1'b0;
    end
  endtask

  logic [7:0] rd, m0, m1;

  initial begin
    n_reset            = 1'b0;
    tb_drv             = 1'b0;
    tb_wdata           = 8'h00;
    bus_if.periph_sel  = 1'b0;
    bus_if.bus_we      = 1'b0;
    bus_if.bus_oe      = 1'b0;
    bus_if.periph_addr = 2'd0;
    bus_if.cs          = 1'b1;
    bus_if.sck         = 1'b0;
    bus_if.mosi        = 1'b0;

    // Reset state
    tick(3);
    check("rst_miso", bus_if.miso, 1'b0);
    check("rst_miso_oe", bus_if.miso_oe, 1'b0);
    check("rst_irq", bus_if.interrupt, 1'b0);
    n_reset = 1'b1;
    tick(3);
    bus_read(2'd1, rd); check("rst_status", rd, 8'h02);
    bus_read(2'd0, rd); check("rst_data", rd, 8'h00);
    bus_read(2'd2, rd); check("rst_ctrl", rd, 8'h00);
    bus_read(2'd3, rd); check("reg3_zero", rd, 8'h00);

    // Basic byte: tx 0xA5, rx 0x3C
    bus_write(2'd2, 8'h01);
    bus_read(2'd2, rd); check("ctrl_en", rd, 8'h01);
    bus_write(2'd0, 8'hA5);
    bus_read(2'd1, rd); check("status_txfull", rd, 8'h00);
    bus_if.cs = 1'b0;
    tick(6);
    bus_read(2'd1, rd); check("status_busy", rd, 8'h0A);
    check("miso_oe_on", bus_if.miso_oe, 1'b1);
    spi_bits(8'h3C, 8, m0);
    check("miso_A5", m0, 8'hA5);
    tick(6);
    bus_read(2'd1, rd); check("status_0B", rd, 8'h0B);
    bus_if.cs = 1'b1;
    tick(6);
    bus_read(2'd1, rd); check("status_03", rd, 8'h03);
    check("miso_oe_off", bus_if.miso_oe, 1'b0);
    check("irq_en_off", bus_if.interrupt, 1'b0);
    bus_read(2'd0, rd); check("data_3C", rd, 8'h3C);
    bus_read(2'd1, rd); check("status_after_rd", rd, 8'h02);

    // Two bytes without CPU read, tx empty then mid-byte DATA write
    bus_if.cs = 1'b0;
    tick(6);
    fork
      spi_bits(8'h11, 8, m0);
      begin
        tick(30);
        bus_write(2'd0, 8'h5A);
      end
    join
    check("miso_empty_zero", m0, 8'h00);
    spi_bits(8'h22, 8, m1);
    check("miso_next_5A", m1, 8'h5A);
    tick(6);
    bus_read(2'd1, rd); check("status_ovr", rd, 8'h0F);
    bus_if.cs = 1'b1;
    tick(6);
    bus_read(2'd0, rd); check("data_keeps_11", rd, 8'h11);
    bus_read(2'd1, rd); check("status_ovr_only", rd, 8'h06);
    bus_write(2'd1, 8'h04);
    bus_read(2'd1, rd); check("ovr_cleared", rd, 8'h02);

    // Partial byte discarded, next byte intact
    bus_if.cs = 1'b0;
    tick(6);
    spi_bits(8'hFF, 5, m0);
    tick(6);
    bus_if.cs = 1'b1;
    tick(6);
    bus_read(2'd1, rd); check("partial_discard", rd, 8'h02);
    bus_if.cs = 1'b0;
    tick(6);
    spi_bits(8'h80, 8, m0);
    tick(6);
    bus_if.cs = 1'b1;
    tick(6);
    bus_read(2'd0, rd); check("data_80", rd, 8'h80);

    // Enable cleared mid-byte
    bus_if.cs = 1'b0;
    tick(6);
    spi_bits(8'h00, 3, m0);
    check("oe_mid_byte", bus_if.miso_oe, 1'b1);
    bus_write(2'd2, 8'h00);
    tick(2);
    check("oe_dis", bus_if.miso_oe, 1'b0);
    bus_if.cs = 1'b1;
    tick(6);
    bus_read(2'd1, rd); check("dis_status", rd, 8'h02);

    // Interrupt behaviour (tied 0 unless the IRQ build)
    bus_write(2'd2, 8'h03);
    tick(3);
    check("irq_idle", bus_if.interrupt, 1'b0);
    bus_read(2'd2, rd); check("ctrl_irq_bit", rd, {6'd0, IRQ, 1'b1});
    bus_if.cs = 1'b0;
    tick(6);
    check("irq_tx_empty", bus_if.interrupt, IRQ);
    spi_bits(8'h77, 8, m0);
    tick(4);
    bus_if.cs = 1'b1;
    tick(6);
    check("irq_rx", bus_if.interrupt, IRQ);
    bus_read(2'd0, rd); check("data_77", rd, 8'h77);
    tick(2);
    check("irq_cleared", bus_if.interrupt, 1'b0);

    // Reset mid-transfer
    bus_write(2'd0, 8'hFF);
    bus_if.cs = 1'b0;
    tick(6);
    spi_bits(8'h00, 3, m0);
    check("pre_rst_oe", bus_if.miso_oe, 1'b1);
    check("pre_rst_miso", bus_if.miso, 1'b1);
    n_reset = 1'b0;
    #1;
    check("mid_rst_miso", bus_if.miso, 1'b0);
    check("mid_rst_oe", bus_if.miso_oe, 1'b0);
    check("mid_rst_irq", bus_if.interrupt, 1'b0);
    bus_if.periph_addr = 2'd1;
    bus_if.periph_sel  = 1'b1;
    bus_if.bus_oe      = 1'b1;
    #1;
    check("mid_rst_status", bus_data, 8'h02);
    bus_if.periph_sel  = 1'b0;
    bus_if.bus_oe      = 1'b0;
    bus_if.cs          = 1'b1;
    tick(2);
    n_reset = 1'b1;
    tick(3);
    bus_read(2'd1, rd); check("post_rst_status", rd, 8'h02);
    bus_read(2'd2, rd); check("post_rst_ctrl", rd, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
